// File: rtl/io_pkg.sv
// io_pkg: shared types and constants for the core IO peripherals.
package io_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int WORD_BYTES = 4;
  localparam int IO_ADDR = 0;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word fall-through read data and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  assign dout = mem[rd_ptr];
  assign full = level == FULL_LVL;
  assign empty = level == '0;
endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: buffers core output words and sends each as four LSB-first UART frames.
// Define IO_UART_PARITY_EN to add an even parity bit to every frame (8E1 instead of 8N1).
module io_uart_tx
  import io_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   din,
  input  logic                          din_valid,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);
`ifdef IO_UART_PARITY_EN
  localparam uart_state_t AFTER_DATA = PARITY;
`else
  localparam uart_state_t AFTER_DATA = STOP;
`endif
  uart_state_t state, state_nx;
  logic [15:0] baud;
  logic [2:0] bit_cnt;
  logic [1:0] byte_idx;
  logic [31:0] shreg, shreg_nx, fifo_dout;
  logic full, empty, push, pop, bit_end, tx_nx, par_nx;
  assign push = din_valid && !full;
  assign pop = state == IDLE && !empty;
  assign bit_end = baud == BAUD_MAX;
  assign busy = state != IDLE || !empty;
  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      byte_idx <= '0;
      shreg <= '0;
      tx <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      baud <= (state_nx != state || bit_end || state == IDLE) ? '0 : baud + 1'b1;
      bit_cnt <= state_nx != state ? '0 : (state == DATA && bit_end) ? bit_cnt + 1'b1 : bit_cnt;
      byte_idx <= pop ? '0 : (state == STOP && state_nx == START) ? byte_idx + 1'b1 : byte_idx;
      shreg <= shreg_nx;
      tx <= tx_nx;
      overflow <= overflow | (din_valid & full);
    end
`ifdef IO_UART_PARITY_EN
  logic par;
  always_ff @(posedge clk or negedge reset)
    if (!reset) par <= 1'b0;
    else par <= par_nx;
  assign par_nx = state == START ? 1'b0 : (state == DATA && bit_end) ? par ^ shreg[0] : par;
`else
  assign par_nx = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = empty ? IDLE : START;
      START:   state_nx = bit_end ? DATA : START;
      DATA:    state_nx = (bit_end && bit_cnt == LAST_BIT) ? AFTER_DATA : DATA;
      PARITY:  state_nx = bit_end ? STOP : PARITY;
      STOP:    state_nx = !bit_end ? STOP : byte_idx == LAST_BYTE ? IDLE : START;
      default: state_nx = IDLE;
    endcase
  end
  // tx is computed from the next state so the registered line changes together with the state
  always_comb begin
    shreg_nx = pop ? fifo_dout : (state == DATA && bit_end) ? shreg >> 1 : shreg;
    tx_nx = state_nx == START ? 1'b0 :
            state_nx == DATA ? shreg_nx[0] :
            state_nx == PARITY ? par_nx : 1'b1;
  end
endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed checks of io_uart_tx with CLK_DIV=4, FIFO_DEPTH=4; honours IO_UART_PARITY_EN.
module tb_io_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int DEPTH = 4;
`ifdef IO_UART_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int WORD_CYC = 4 * FBITS * CLK_DIV;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din_valid = 1'b0;
  logic [31:0] din = '0;
  logic tx, busy, overflow;
  logic [2:0] fifo_level;
  int n_chk = 0;
  int n_fail = 0;
  int n;
  logic [31:0] w;
  always #5 clk = ~clk;
  io_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .din_valid(din_valid),
    .tx(tx),
    .busy(busy),
    .overflow(overflow),
    .fifo_level(fifo_level)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_start(output int cnt);
    cnt = 0;
    while (tx !== 1'b0 && cnt < 1000) begin
      tick();
      cnt++;
    end
    chk("start_found", {31'd0, tx}, 32'd0);
  endtask
  // called in cycle 0 of the first start bit; returns in cycle 1 of the last stop bit
  task automatic rx_word(output logic [31:0] word);
    logic [7:0] b;
    word = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (CLK_DIV) tick();
      chk("start_bit", {31'd0, tx}, 32'd0);
      for (int j = 0; j < 8; j++) begin
        repeat (CLK_DIV) tick();
        b[j] = tx;
      end
`ifdef IO_UART_PARITY_EN
      repeat (CLK_DIV) tick();
      chk("parity_bit", {31'd0, tx}, {31'd0, ^b});
`endif
      repeat (CLK_DIV) tick();
      chk("stop_bit", {31'd0, tx}, 32'd1);
      word[8*k +: 8] = b;
    end
  endtask
  task automatic write(input logic [31:0] d);
    din = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask
  initial begin
    tick();
    chk("rst_state", {tx, busy, overflow, fifo_level}, {1'b1, 1'b0, 1'b0, 3'd0});
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle", {tx, busy, fifo_level}, {1'b1, 1'b0, 3'd0});
    end
    write(32'h44332211);
    wait_start(n);
    chk("start_latency", n, 1);
    rx_word(w);
    chk("single_word", w, 32'h44332211);
    repeat (2) tick();
    chk("busy_last_cycle", {31'd0, busy}, 32'd1);
    tick();
    chk("busy_fall", {tx, busy, fifo_level}, {1'b1, 1'b0, 3'd0});
    fork
      begin
        for (int i = 1; i <= 6; i++) write(i);
        chk("burst_level", {29'd0, fifo_level}, 32'd4);
        chk("burst_overflow", {31'd0, overflow}, 32'd1);
      end
      begin
        wait_start(n);
        chk("burst_latency", n, 2);
        for (int i = 1; i <= 5; i++) begin
          if (i > 1) begin
            wait_start(n);
            chk("burst_gap", n, 4);
          end
          rx_word(w);
          chk("burst_word", w, i);
        end
      end
    join
    repeat (3) tick();
    chk("burst_drained", {tx, busy, overflow, fifo_level}, {1'b1, 1'b0, 1'b1, 3'd0});
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("no_sixth_word", {31'd0, tx}, 32'd1);
    end
    reset = 1'b0;
    #1;
    chk("ovf_cleared", {overflow, fifo_level}, {1'b0, 3'd0});
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) write(32'h100 + i);
    repeat (WORD_CYC - 3) tick();
    chk("pre_drop_state", {tx, overflow, fifo_level}, {1'b1, 1'b0, 3'd4});
    write(32'hDEAD_BEEF);
    chk("drop_on_pop", {tx, overflow, fifo_level}, {1'b0, 1'b1, 3'd3});
    reset = 1'b0;
    tick();
    reset = 1'b1;
    write(32'h1234_0055);
    wait_start(n);
    repeat (52) tick();
    chk("pre_abort_tx", {31'd0, tx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("abort", {tx, busy, fifo_level}, {1'b1, 1'b0, 3'd0});
    tick();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("after_abort", {tx, busy}, {1'b1, 1'b0});
    end
    write(32'hA5C3_0F01);
    wait_start(n);
    chk("post_abort_latency", n, 1);
    rx_word(w);
    chk("post_abort_word", w, 32'hA5C3_0F01);
    repeat (3) tick();
    chk("post_abort_idle", {31'd0, busy}, 32'd0);
`ifdef IO_UART_PARITY_EN
    write(32'h0000_0007);
    wait_start(n);
    rx_word(w);
    chk("parity_word", w, 32'h0000_0007);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Output peripheral on the core's IO port; consumes the 32-bit word and strobe the core emits on every store to data address 0.
- Buffers words in a small FIFO, because the core has no stall path.
- Serialises each word as four 8N1 UART frames, least-significant byte first, on a single tx line.
- Sits directly downstream of the core at the top level; it is the only path from program output to the outside world.

Parameters:
- CLK_DIV, 16: clock cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 8: word entries in the FIFO; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- din  input  32  word to transmit; connects to core dout.
- din_valid  input  1  one-cycle write strobe; connects to core dout_ready.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while the FIFO is non-empty or a frame is in flight.
- overflow  output  1  sticky; set when a write is dropped.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of words currently held in the FIFO.

Behaviour:
- Reset (reset = 0, asynchronous):
  - tx = 1; busy = 0; overflow = 0; fifo_level = 0.
  - FIFO pointers cleared; state = IDLE; baud counter, bit counter and byte index = 0.
- Reset asserted mid-frame aborts the frame immediately: tx goes high with no stop bit, and FIFO contents are lost.
- FIFO write: on a rising edge with din_valid = 1 and fifo_level < FIFO_DEPTH, din is stored.
- Overflow: din_valid = 1 while fifo_level == FIFO_DEPTH drops the word and sets overflow = 1.
  - This applies even if a pop happens in the same cycle; fullness comes from the registered level.
  - overflow clears only on reset.
- FIFO pop: only in IDLE when fifo_level > 0. The popped word loads a 32-bit shift register, byte index = 0, next state START.
- Simultaneous push and pop: fifo_level is unchanged and both operations take effect.
- States:
  - IDLE: tx = 1.
  - START: tx = 0 for CLK_DIV cycles.
  - DATA: tx = shreg[0] for CLK_DIV cycles per bit. After each bit, shreg shifts right by 1. After 8 bits go to STOP (or PARITY, see Optional Feature).
  - STOP: tx = 1 for CLK_DIV cycles. At the end, if byte index < 3, increment it and go to START. If byte index == 3, go to IDLE.
- Baud counter: counts 0..CLK_DIV-1 and resets to 0 on every state change. A bit period ends when the counter reaches CLK_DIV-1.
- Latency: din_valid at cycle N gives a FIFO write at the end of N and a pop in IDLE at the end of N+1. The tx falling edge (start bit) is at cycle N+2 when the block was idle.
- Frame timing: one word = 4 x 10 bits x CLK_DIV cycles. The following word's start bit comes one IDLE cycle after the final stop bit.
- busy = (state != IDLE) or (fifo_level != 0); registered-state derived, no combinational path from din_valid.
- tx is driven directly from a flop (glitch-free).

Optional Feature:
- Macro: IO_UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = even parity (XOR of the 8 data bits) for CLK_DIV cycles, so each frame is 11 bits (8E1).
- Undefined: no PARITY state; frame is 8N1, 10 bits.

Decomposition:
- Package io_pkg holds:
  - uart_state_t enum: IDLE, START, DATA, PARITY, STOP. PARITY is present in the enum even when unused.
  - Constants UART_DATA_BITS = 8, WORD_BYTES = 4, IO_ADDR = 0.
- Sub-module sync_fifo, parameterised width and depth:
  - Ports: push, pop, din, dout (first-word fall-through), full, empty, level.
  - The top level contains the overflow flag, the serialiser FSM, and the baud and bit counters.

Test Plan (CLK_DIV = 4, FIFO_DEPTH = 4, parity off unless stated):
- Reset release with no writes: tx = 1, busy = 0, fifo_level = 0 for 100 cycles.
- Single write of 0x44332211: tx emits bytes 0x11, 0x22, 0x33, 0x44 LSB first, each framed 0/data/1, 4 cycles per bit. busy falls exactly 160 cycles after the start-bit edge. The start bit begins 2 cycles after the strobe.
- Six back-to-back strobes (words 1..6): the first is popped immediately, 4 more are queued, and the 6th is dropped. Expect overflow = 1, five words transmitted, and no gap longer than 1 IDLE cycle between words.
- Strobe on the same cycle as an IDLE pop with FIFO full: the word is dropped, overflow = 1, and fifo_level goes from 4 to 3.
- reset pulled low in the middle of byte 2's DATA bits: tx = 1 that cycle, FIFO empty, no further frames; the next write transmits normally.
- IO_UART_PARITY_EN defined, write 0x00000007: the first frame is 11 bits with parity bit 1; bytes 0x00 carry parity 0.
